// File: rtl/decode_stage.sv
// decode_stage: instruction decode for the 5-stage MIPS-subset pipeline.
// Decodes the IF/ID instruction and drives the register file read ports.
// Bypasses MEM/WB results into both operands, stalls fetch on RAW hazards
// it cannot bypass, and registers the decoded fields into ID/EX.
module decode_stage #(
  parameter logic [31:0] NOP_INSTR = 32'h00000000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_valid,
  input  logic [31:0] if_instr,
  input  logic [31:0] if_pc,
  input  logic        flush,
  output logic [4:0]  rf_a_addr,
  output logic [4:0]  rf_b_addr,
  input  logic [31:0] rf_a_data,
  input  logic [31:0] rf_b_data,
  input  logic        mem_wr_en,
  input  logic        mem_wr_pending,
  input  logic [4:0]  mem_wr_addr,
  input  logic [31:0] mem_wr_data,
  input  logic        wb_wr_en,
  input  logic [4:0]  wb_wr_addr,
  input  logic [31:0] wb_wr_data,
  output logic        if_stall,
  output logic        id_valid,
  output logic [31:0] id_pc,
  output logic [31:0] id_instr,
  output logic [31:0] id_a,
  output logic [31:0] id_b,
  output logic [31:0] id_imm,
  output logic [4:0]  id_dest,
  output logic        id_reg_write,
  output logic        id_is_load
);

  // Instruction fields
  logic [5:0]  w_op;
  logic [4:0]  w_rs;
  logic [4:0]  w_rt;
  logic [4:0]  w_rd;
  logic [5:0]  w_funct;
  logic [15:0] w_imm16;

  assign w_op    = if_instr[31:26];
  assign w_rs    = if_instr[25:21];
  assign w_rt    = if_instr[20:16];
  assign w_rd    = if_instr[15:11];
  assign w_funct = if_instr[5:0];
  assign w_imm16 = if_instr[15:0];

  assign rf_a_addr = w_rs;
  assign rf_b_addr = w_rt;

  // Decoded control
  logic [4:0]  w_dest;
  logic        w_wr_raw;
  logic        w_reg_write;
  logic        w_is_load;
  logic        w_use_rs;
  logic        w_use_rt;
  logic [31:0] w_imm;

  // Bypassed operands and hazard
  logic [31:0] w_a;
  logic [31:0] w_b;
  logic        w_hazard;
  logic        w_issue;

  // ID/EX pipeline register
  logic        r_vld_p1;
  logic [31:0] r_pc_p1;
  logic [31:0] r_instr_p1;
  logic [31:0] r_a_p1;
  logic [31:0] r_b_p1;
  logic [31:0] r_imm_p1;
  logic [4:0]  r_dest_p1;
  logic        r_reg_write_p1;
  logic        r_is_load_p1;

  // Operand source selection: $0 is hard zero; a ready MEM result beats WB,
  // and WB beats the register file because its write is not yet visible.
  function automatic logic [31:0] bypass(
    input logic [4:0]  addr,
    input logic [31:0] rf_data,
    input logic        m_en,
    input logic        m_pend,
    input logic [4:0]  m_addr,
    input logic [31:0] m_data,
    input logic        w_en,
    input logic [4:0]  w_addr,
    input logic [31:0] w_data
  );
    logic [31:0] res;
    if (addr == 5'd0)
      res = 32'd0;
    else if (m_en && !m_pend && (m_addr == addr))
      res = m_data;
    else if (w_en && (w_addr == addr))
      res = w_data;
    else
      res = rf_data;
    return res;
  endfunction

  // A source register conflicts when the instruction in ID/EX will write it
  // (there is no EX-level bypass) or when a load in MEM has not returned it.
  function automatic logic src_conflict(
    input logic [4:0] r,
    input logic       idex_vld,
    input logic       idex_wr,
    input logic [4:0] idex_dest,
    input logic       m_en,
    input logic       m_pend,
    input logic [4:0] m_addr
  );
    logic res;
    res = (r != 5'd0) &&
          ((idex_vld && idex_wr && (idex_dest == r)) ||
           (m_en && m_pend && (m_addr == r)));
    return res;
  endfunction

  // Opcode decode into destination, write/load flags, source usage, immediate
  always_comb begin
    w_dest    = 5'd0;
    w_wr_raw  = 1'b0;
    w_is_load = 1'b0;
    w_use_rs  = 1'b0;
    w_use_rt  = 1'b0;
    w_imm     = 32'd0;
    case (w_op)
      6'h00: begin
        w_dest   = w_rd;
        w_wr_raw = (w_funct != 6'h08);
        w_use_rt = 1'b1;
        w_use_rs = !((w_funct == 6'h00) || (w_funct == 6'h02) || (w_funct == 6'h03));
      end
      6'h08, 6'h09, 6'h0A, 6'h0B: begin
        w_dest   = w_rt;
        w_wr_raw = 1'b1;
        w_use_rs = 1'b1;
        w_imm    = {{16{w_imm16[15]}}, w_imm16};
      end
      6'h0C, 6'h0D, 6'h0E: begin
        w_dest   = w_rt;
        w_wr_raw = 1'b1;
        w_use_rs = 1'b1;
        w_imm    = {16'd0, w_imm16};
      end
      6'h0F: begin
        w_dest   = w_rt;
        w_wr_raw = 1'b1;
        w_imm    = {w_imm16, 16'd0};
      end
      6'h23: begin
        w_dest    = w_rt;
        w_wr_raw  = 1'b1;
        w_is_load = 1'b1;
        w_use_rs  = 1'b1;
        w_imm     = {{16{w_imm16[15]}}, w_imm16};
      end
      6'h2B, 6'h04, 6'h05: begin
        w_use_rs = 1'b1;
        w_use_rt = 1'b1;
        w_imm    = {{16{w_imm16[15]}}, w_imm16};
      end
      6'h03: begin
        w_dest   = 5'd31;
        w_wr_raw = 1'b1;
      end
      default: begin
        w_dest = 5'd0;
      end
    endcase
  end

  // Writes to $0 are discarded so later hazard checks never match on them
  assign w_reg_write = w_wr_raw && (w_dest != 5'd0);

  // Operand bypass for both read ports
  always_comb begin
    w_a = bypass(w_rs, rf_a_data, mem_wr_en, mem_wr_pending, mem_wr_addr,
                 mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data);
    w_b = bypass(w_rt, rf_b_data, mem_wr_en, mem_wr_pending, mem_wr_addr,
                 mem_wr_data, wb_wr_en, wb_wr_addr, wb_wr_data);
  end

  // Hazard detection; a flush kills the instruction so it never stalls
  always_comb begin
    w_hazard = if_valid && !flush &&
               ((w_use_rs && src_conflict(w_rs, r_vld_p1, r_reg_write_p1, r_dest_p1,
                                          mem_wr_en, mem_wr_pending, mem_wr_addr)) ||
                (w_use_rt && src_conflict(w_rt, r_vld_p1, r_reg_write_p1, r_dest_p1,
                                          mem_wr_en, mem_wr_pending, mem_wr_addr)));
    w_issue  = if_valid && !flush && !w_hazard;
  end

  assign if_stall = w_hazard;

  // ---- stage boundary: ID -> ID/EX (p1) ----
  // Issue the decoded instruction, otherwise insert a bubble
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld_p1       <= 1'b0;
      r_pc_p1        <= 32'd0;
      r_instr_p1     <= NOP_INSTR;
      r_a_p1         <= 32'd0;
      r_b_p1         <= 32'd0;
      r_imm_p1       <= 32'd0;
      r_dest_p1      <= 5'd0;
      r_reg_write_p1 <= 1'b0;
      r_is_load_p1   <= 1'b0;
    end else if (w_issue) begin
      r_vld_p1       <= 1'b1;
      r_pc_p1        <= if_pc;
      r_instr_p1     <= if_instr;
      r_a_p1         <= w_a;
      r_b_p1         <= w_b;
      r_imm_p1       <= w_imm;
      r_dest_p1      <= w_dest;
      r_reg_write_p1 <= w_reg_write;
      r_is_load_p1   <= w_is_load;
    end else begin
      r_vld_p1       <= 1'b0;
      r_pc_p1        <= 32'd0;
      r_instr_p1     <= NOP_INSTR;
      r_a_p1         <= 32'd0;
      r_b_p1         <= 32'd0;
      r_imm_p1       <= 32'd0;
      r_dest_p1      <= 5'd0;
      r_reg_write_p1 <= 1'b0;
      r_is_load_p1   <= 1'b0;
    end
  end

  assign id_valid     = r_vld_p1;
  assign id_pc        = r_pc_p1;
  assign id_instr     = r_instr_p1;
  assign id_a         = r_a_p1;
  assign id_b         = r_b_p1;
  assign id_imm       = r_imm_p1;
  assign id_dest      = r_dest_p1;
  assign id_reg_write = r_reg_write_p1;
  assign id_is_load   = r_is_load_p1;

endmodule

// File: tb/tb_decode_stage.sv
// Testbench for decode_stage: directed pipeline scenarios followed by
// randomized traffic, all compared every cycle against a behavioural model.
module tb_decode_stage;

  localparam logic [31:0] NOP = 32'h00000000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b0;
  logic        if_valid = 1'b0;
  logic [31:0] if_instr = 32'd0;
  logic [31:0] if_pc = 32'd0;
  logic        flush = 1'b0;
  logic [4:0]  rf_a_addr, rf_b_addr;
  logic [31:0] rf_a_data, rf_b_data;
  logic        mem_wr_en = 1'b0;
  logic        mem_wr_pending = 1'b0;
  logic [4:0]  mem_wr_addr = 5'd0;
  logic [31:0] mem_wr_data = 32'd0;
  logic        wb_wr_en = 1'b0;
  logic [4:0]  wb_wr_addr = 5'd0;
  logic [31:0] wb_wr_data = 32'd0;
  logic        if_stall, id_valid, id_reg_write, id_is_load;
  logic [31:0] id_pc, id_instr, id_a, id_b, id_imm;
  logic [4:0]  id_dest;

  // Register file contents as seen by the read ports
  logic [31:0] regs [32];
  assign rf_a_data = regs[if_instr[25:21]];
  assign rf_b_data = regs[if_instr[20:16]];

  decode_stage #(.NOP_INSTR(NOP)) dut (
    .clk(clk), .rst(rst), .if_valid(if_valid), .if_instr(if_instr), .if_pc(if_pc),
    .flush(flush), .rf_a_addr(rf_a_addr), .rf_b_addr(rf_b_addr),
    .rf_a_data(rf_a_data), .rf_b_data(rf_b_data),
    .mem_wr_en(mem_wr_en), .mem_wr_pending(mem_wr_pending), .mem_wr_addr(mem_wr_addr),
    .mem_wr_data(mem_wr_data), .wb_wr_en(wb_wr_en), .wb_wr_addr(wb_wr_addr),
    .wb_wr_data(wb_wr_data), .if_stall(if_stall), .id_valid(id_valid), .id_pc(id_pc),
    .id_instr(id_instr), .id_a(id_a), .id_b(id_b), .id_imm(id_imm), .id_dest(id_dest),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load)
  );

  int checks = 0;
  int errors = 0;
  logic run = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic        urs;
    logic        urt;
    logic        wr;
    logic        ld;
    logic        immdef;
    logic [4:0]  dest;
    logic [31:0] imm;
  } dec_t;

  function automatic dec_t dec(input logic [31:0] ins);
    dec_t d;
    logic [5:0]  op;
    logic [31:0] sx, zx;
    op = ins[31:26];
    sx = {{16{ins[15]}}, ins[15:0]};
    zx = {16'h0000, ins[15:0]};
    d = '0;
    if (op == 6'h00) begin
      d.dest = ins[15:11];
      d.wr   = (ins[5:0] != 6'h08);
      d.urt  = 1'b1;
      d.urs  = !(ins[5:0] inside {6'h00, 6'h02, 6'h03});
    end else if (op inside {[6'h08:6'h0B]}) begin
      d.dest = ins[20:16]; d.wr = 1'b1; d.urs = 1'b1; d.imm = sx; d.immdef = 1'b1;
    end else if (op inside {[6'h0C:6'h0E]}) begin
      d.dest = ins[20:16]; d.wr = 1'b1; d.urs = 1'b1; d.imm = zx; d.immdef = 1'b1;
    end else if (op == 6'h0F) begin
      d.dest = ins[20:16]; d.wr = 1'b1; d.imm = ins[15:0] * 32'h10000; d.immdef = 1'b1;
    end else if (op == 6'h23) begin
      d.dest = ins[20:16]; d.wr = 1'b1; d.ld = 1'b1; d.urs = 1'b1; d.imm = sx; d.immdef = 1'b1;
    end else if (op inside {6'h2B, 6'h04, 6'h05}) begin
      d.urs = 1'b1; d.urt = 1'b1; d.imm = sx; d.immdef = 1'b1;
    end else if (op == 6'h03) begin
      d.dest = 5'd31; d.wr = 1'b1;
    end
    if (d.dest == 5'd0) d.wr = 1'b0;
    return d;
  endfunction

  // Model ID/EX contents
  logic        m_valid, m_wr, m_ld, m_immdef;
  logic [31:0] m_pc, m_instr, m_a, m_b, m_imm;
  logic [4:0]  m_dest;

  function automatic logic [31:0] fwd(input logic [4:0] r);
    if (r == 5'd0) return 32'd0;
    if (mem_wr_en && !mem_wr_pending && mem_wr_addr == r) return mem_wr_data;
    if (wb_wr_en && wb_wr_addr == r) return wb_wr_data;
    return regs[r];
  endfunction

  function automatic logic busy(input logic [4:0] r);
    return (r != 5'd0) && ((m_valid && m_wr && m_dest == r) ||
                           (mem_wr_en && mem_wr_pending && mem_wr_addr == r));
  endfunction

  function automatic logic stall_m();
    dec_t d;
    d = dec(if_instr);
    return if_valid && !flush &&
           ((d.urs && busy(if_instr[25:21])) || (d.urt && busy(if_instr[20:16])));
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst || !(if_valid && !flush && !stall_m())) begin
      m_valid <= 1'b0; m_pc <= 32'd0; m_instr <= NOP; m_a <= 32'd0; m_b <= 32'd0;
      m_imm <= 32'd0; m_immdef <= 1'b1; m_dest <= 5'd0; m_wr <= 1'b0; m_ld <= 1'b0;
    end else begin
      m_valid <= 1'b1; m_pc <= if_pc; m_instr <= if_instr;
      m_a <= fwd(if_instr[25:21]); m_b <= fwd(if_instr[20:16]);
      m_imm <= dec(if_instr).imm; m_immdef <= dec(if_instr).immdef;
      m_dest <= dec(if_instr).dest; m_wr <= dec(if_instr).wr; m_ld <= dec(if_instr).ld;
    end
  end

  // Per-cycle comparison against the model, on the falling edge
  always @(negedge clk) begin
    if (run && !rst) begin
      chk("id_valid", {31'd0, id_valid}, {31'd0, m_valid});
      chk("id_pc", id_pc, m_pc);
      chk("id_instr", id_instr, m_instr);
      chk("id_a", id_a, m_a);
      chk("id_b", id_b, m_b);
      if (m_immdef) chk("id_imm", id_imm, m_imm);
      chk("id_dest", {27'd0, id_dest}, {27'd0, m_dest});
      chk("id_reg_write", {31'd0, id_reg_write}, {31'd0, m_wr});
      chk("id_is_load", {31'd0, id_is_load}, {31'd0, m_ld});
      chk("if_stall", {31'd0, if_stall}, {31'd0, stall_m()});
      chk("rf_a_addr", {27'd0, rf_a_addr}, {27'd0, if_instr[25:21]});
      chk("rf_b_addr", {27'd0, rf_b_addr}, {27'd0, if_instr[20:16]});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] ins, input logic [31:0] pc);
    if_valid = 1'b1;
    if_instr = ins;
    if_pc    = pc;
  endtask

  logic [5:0] ops [16] = '{6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E,
                           6'h0F, 6'h23, 6'h2B, 6'h04, 6'h05, 6'h02, 6'h03, 6'h3F};
  logic [5:0] functs [6] = '{6'h20, 6'h22, 6'h08, 6'h00, 6'h02, 6'h03};

  initial begin
    logic        s;
    logic [31:0] ins;
    for (int k = 0; k < 32; k++) regs[k] = 32'h1000 + k;

    // Reset state
    #3 rst = 1'b1;
    #1;
    chk("reset id_valid", {31'd0, id_valid}, 32'd0);
    chk("reset id_instr", id_instr, NOP);
    chk("reset if_stall", {31'd0, if_stall}, 32'd0);
    tick();
    rst = 1'b0;
    run = 1'b1;

    // addi $8,$9,-4 with rs data 10
    regs[9] = 32'd10;
    issue(32'h2128FFFC, 32'h100);
    tick();
    chk("addi id_a", id_a, 32'd10);
    chk("addi id_imm", id_imm, 32'hFFFFFFFC);
    chk("addi id_dest", {27'd0, id_dest}, 32'd8);
    chk("addi id_reg_write", {31'd0, id_reg_write}, 32'd1);
    issue(32'h3528FFFC, 32'h104);
    tick();
    chk("ori id_imm", id_imm, 32'h0000FFFC);
    issue(32'h3C08FFFC, 32'h108);
    tick();
    chk("lui id_imm", id_imm, 32'hFFFC0000);

    // Bypass priority on rs=5
    regs[5] = 32'hCCCC;
    mem_wr_en = 1'b1; mem_wr_addr = 5'd5; mem_wr_data = 32'hAAAA;
    wb_wr_en = 1'b1;  wb_wr_addr = 5'd5;  wb_wr_data = 32'hBBBB;
    issue(32'h20A60000, 32'h10C);
    tick();
    chk("bypass mem", id_a, 32'hAAAA);
    mem_wr_en = 1'b0;
    issue(32'h20A60000, 32'h110);
    tick();
    chk("bypass wb", id_a, 32'hBBBB);
    mem_wr_en = 1'b1; mem_wr_addr = 5'd0; wb_wr_addr = 5'd0;
    issue(32'h20060000, 32'h114);
    tick();
    chk("bypass r0", id_a, 32'd0);
    mem_wr_en = 1'b0; wb_wr_en = 1'b0;

    // Back-to-back RAW: add $3,$1,$2 ; sub $4,$3,$1
    issue(32'h00221820, 32'h118);
    tick();
    issue(32'h00612022, 32'h11C);
    #1;
    chk("raw stall", {31'd0, if_stall}, 32'd1);
    tick();
    chk("raw bubble", {31'd0, id_valid}, 32'd0);
    chk("raw stall released", {31'd0, if_stall}, 32'd0);
    tick();
    chk("raw sub issued", id_instr, 32'h00612022);

    // Pending load feeding sw rt=7
    regs[7] = 32'h5555;
    mem_wr_en = 1'b1; mem_wr_pending = 1'b1; mem_wr_addr = 5'd7;
    issue(32'hAC270000, 32'h120);
    #1;
    chk("load stall", {31'd0, if_stall}, 32'd1);
    tick();
    chk("load stall held", {31'd0, if_stall}, 32'd1);
    chk("load bubble", {31'd0, id_valid}, 32'd0);
    mem_wr_pending = 1'b0; mem_wr_data = 32'h1234;
    tick();
    chk("load id_b", id_b, 32'h1234);

    // Flush during a hazard
    mem_wr_pending = 1'b1;
    flush = 1'b1;
    #1;
    chk("flush stall", {31'd0, if_stall}, 32'd0);
    tick();
    chk("flush bubble", {31'd0, id_valid}, 32'd0);
    flush = 1'b0; mem_wr_en = 1'b0; mem_wr_pending = 1'b0;

    // jal writes $31
    issue(32'h0C000010, 32'h124);
    tick();
    chk("jal id_dest", {27'd0, id_dest}, 32'd31);
    chk("jal id_reg_write", {31'd0, id_reg_write}, 32'd1);

    // Reset mid-operation while ID/EX is live
    if_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    chk("midrst id_valid", {31'd0, id_valid}, 32'd0);
    chk("midrst id_instr", id_instr, NOP);
    chk("midrst id_pc", id_pc, 32'd0);
    chk("midrst id_dest", {27'd0, id_dest}, 32'd0);
    chk("midrst if_stall", {31'd0, if_stall}, 32'd0);
    tick();
    rst = 1'b0;

    // Destination $0 never writes
    issue(32'h20200005, 32'h128);
    tick();
    chk("r0 dest id_reg_write", {31'd0, id_reg_write}, 32'd0);
    chk("r0 dest id_valid", {31'd0, id_valid}, 32'd1);

    // Randomized traffic; a stalled instruction is re-presented unchanged
    s = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      if (!s) begin
        ins = $urandom;
        ins[31:26] = ops[$urandom_range(0, 15)];
        ins[25:21] = 5'($urandom_range(0, 7));
        ins[20:16] = 5'($urandom_range(0, 7));
        ins[15:11] = 5'($urandom_range(0, 7));
        if (ins[31:26] == 6'h00) ins[5:0] = functs[$urandom_range(0, 5)];
        if_instr = ins;
        if_pc    = $urandom;
        if_valid = ($urandom_range(0, 4) != 0);
      end
      for (int k = 0; k < 32; k++) regs[k] = $urandom;
      flush          = ($urandom_range(0, 9) == 0);
      mem_wr_en      = $urandom_range(0, 1) != 0;
      mem_wr_pending = ($urandom_range(0, 3) == 0);
      mem_wr_addr    = 5'($urandom_range(0, 7));
      mem_wr_data    = $urandom;
      wb_wr_en       = $urandom_range(0, 1) != 0;
      wb_wr_addr     = 5'($urandom_range(0, 7));
      wb_wr_data     = $urandom;
      s = stall_m();
      tick();
    end

    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
